// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// Single-byte SPI master, mode 0 (SCLK idles low, both ends sample on the
// rising SCLK edge, data changes on the falling edge), LSB first.
//
// Parameters
//   CLK_DIV   CLK cycles per SCLK half-period (1..255)
//
// Ports
//   CLK       system clock, rising-edge active
//   CLR       synchronous active-high reset, wins over everything
//   TX_DATA   byte to send, captured only on an accepted handshake
//   TX_VALID  upstream has a byte for us
//   TX_READY  block can accept a byte (decoded: state == IDLE)
//   RX_DATA   last fully received byte, updated on DONE
//   RX_VALID  one-cycle pulse when RX_DATA has just been updated
//   BUSY      decoded: state != IDLE
//   SCLK      serial clock
//   CS_N      active-low slave select
//   MOSI      serial data out
//   MISO      serial data in
//
// Handshake: a byte is transferred on a rising CLK edge where TX_VALID=1,
// TX_READY=1 and CLR=0. TX_VALID while not ready is simply ignored; nothing
// is queued, so upstream must hold TX_VALID until it sees the accept.
//
// Timing from the accept edge (edge 0), D = CLK_DIV:
//   edge k*D, k = 1..16 : SCLK toggle k (odd k rising, even k falling)
//   edge 16*D           : 8th falling toggle, state -> DONE, RX_VALID=1
//   edge 16*D+1         : state -> IDLE, TX_READY=1
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       BUSY,
  output logic       SCLK,
  output logic       CS_N,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t     state;
  logic [7:0] div_cnt;   // 0..CLK_DIV-1, cleared on every SCLK toggle
  logic [7:0] tx_shift;  // bit 0 is always the bit currently on MOSI
  logic [7:0] rx_shift;  // fills from the MSB, so the first bit ends in [0]
  logic [2:0] fall_cnt;  // falling SCLK toggles seen in this byte
  logic       tick;

  assign tick     = (div_cnt == DIV_LAST);
  assign TX_READY = (state == IDLE);
  assign BUSY     = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state    <= IDLE;
      div_cnt  <= 8'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      fall_cnt <= 3'd0;
      RX_DATA  <= 8'd0;
      RX_VALID <= 1'b0;
      SCLK     <= 1'b0;
      CS_N     <= 1'b1;
      MOSI     <= 1'b0;
    end else begin
      RX_VALID <= 1'b0;
      case (state)
        IDLE: begin
          SCLK <= 1'b0;
          CS_N <= 1'b1;
          MOSI <= 1'b0;
          if (TX_VALID) begin
            tx_shift <= TX_DATA;
            rx_shift <= 8'd0;
            div_cnt  <= 8'd0;
            fall_cnt <= 3'd0;
            CS_N     <= 1'b0;
            MOSI     <= TX_DATA[0];
            state    <= SETUP;
          end
        end

        SETUP: begin
          if (tick) begin
            // First rising SCLK edge: the slave's bit 0 is sampled here.
            div_cnt  <= 8'd0;
            SCLK     <= 1'b1;
            rx_shift <= {MISO, rx_shift[7:1]};
            state    <= SHIFT;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        SHIFT: begin
          if (tick) begin
            div_cnt <= 8'd0;
            if (!SCLK) begin
              SCLK     <= 1'b1;
              rx_shift <= {MISO, rx_shift[7:1]};
            end else begin
              SCLK <= 1'b0;
              if (fall_cnt == 3'd7) begin
                // All eight bits are in; the last sample happened on the
                // preceding rising toggle, so rx_shift is complete.
                CS_N     <= 1'b1;
                MOSI     <= 1'b0;
                RX_DATA  <= rx_shift;
                RX_VALID <= 1'b1;
                fall_cnt <= 3'd0;
                tx_shift <= 8'd0;
                state    <= DONE;
              end else begin
                tx_shift <= {1'b0, tx_shift[7:1]};
                MOSI     <= tx_shift[1];
                fall_cnt <= fall_cnt + 3'd1;
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Two instances side by side: index 0 with CLK_DIV=2, index 1 with CLK_DIV=1.
// MISO for each instance comes from a selectable source: loopback of MOSI,
// tied high, or a fixed 8-bit pattern presented one bit per SCLK pulse.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] clr      = 2'b11;
  logic [1:0] tx_valid = 2'b00;
  logic [7:0] tx_data [2] = '{8'h00, 8'h00};
  logic [1:0] miso;

  wire [1:0] tx_ready, rx_valid, busy, sclk, cs_n, mosi;
  wire [7:0] rx_data [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    spi_master_ctrl #(.CLK_DIV((g == 0) ? 2 : 1)) u_dut (
      .CLK     (clk),
      .CLR     (clr[g]),
      .TX_DATA (tx_data[g]),
      .TX_VALID(tx_valid[g]),
      .TX_READY(tx_ready[g]),
      .RX_DATA (rx_data[g]),
      .RX_VALID(rx_valid[g]),
      .BUSY    (busy[g]),
      .SCLK    (sclk[g]),
      .CS_N    (cs_n[g]),
      .MOSI    (mosi[g]),
      .MISO    (miso[g])
    );
  end

  function automatic int div_of(input int sel);
    return (sel == 0) ? 2 : 1;
  endfunction

  // ------------------------------------------------------------ MISO sources
  int         miso_mode [2] = '{0, 0};   // 0 loopback, 1 tied high, 2 pattern
  logic [7:0] miso_pat  [2] = '{8'h00, 8'h00};
  int         rise_cnt  [2] = '{0, 0};
  int         tog_cnt   [2] = '{0, 0};
  logic [7:0] mosi_cap  [2] = '{8'h00, 8'h00};
  logic [1:0] mosi_or = 2'b00;
  logic [1:0] sclk_q  = 2'b00;

  always_comb begin
    miso = 2'b00;
    for (int i = 0; i < 2; i++) begin
      case (miso_mode[i])
        0:       miso[i] = mosi[i];
        1:       miso[i] = 1'b1;
        default: miso[i] = (rise_cnt[i] < 8) ? miso_pat[i][rise_cnt[i][2:0]] : 1'b0;
      endcase
    end
  end

  // Observer: records MOSI at each rising SCLK seen with CS_N low, counts
  // pulses and toggles; cleared whenever the instance is idle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!busy[i]) begin
        rise_cnt[i] <= 0;
        tog_cnt[i]  <= 0;
        mosi_cap[i] <= 8'h00;
        mosi_or[i]  <= 1'b0;
      end else begin
        if (sclk[i] && !sclk_q[i] && !cs_n[i]) begin
          if (rise_cnt[i] < 8) mosi_cap[i][rise_cnt[i][2:0]] <= mosi[i];
          rise_cnt[i] <= rise_cnt[i] + 1;
        end
        if (sclk[i] != sclk_q[i]) tog_cnt[i] <= tog_cnt[i] + 1;
        mosi_or[i] <= mosi_or[i] | mosi[i];
      end
      sclk_q[i] <= sclk[i];
    end
  end

  // ---------------------------------------------------------------- scoreboard
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input int sel,
                       input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h expected %0h", name, sel, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic wait_ready(input int sel);
    int n;
    n = 0;
    while (tx_ready[sel] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("ready_wait", sel, 32'(tx_ready[sel]), 32'd1);
  endtask

  // One full transfer; returns received byte, latency (accept edge to the
  // edge that raises RX_VALID, -1 on timeout) and observed MOSI stream.
  task automatic do_xfer(input int sel, input logic [7:0] tx, input int mode,
                         input logic [7:0] pat, output logic [7:0] got_rx,
                         output int lat, output logic [7:0] got_mosi,
                         output int pulses, output logic got_or);
    miso_mode[sel] = mode;
    miso_pat[sel]  = pat;
    wait_ready(sel);
    tx_data[sel]  = tx;
    tx_valid[sel] = 1'b1;
    @(posedge clk); #1;
    tx_valid[sel] = 1'b0;
    check("accept_busy", sel, 32'(busy[sel]), 32'd1);
    lat = -1;
    got_rx = 8'hxx;
    got_mosi = 8'hxx;
    pulses = -1;
    got_or = 1'bx;
    for (int n = 1; n <= 16 * div_of(sel) + 20; n++) begin
      @(posedge clk); #1;
      if (rx_valid[sel]) begin
        lat = n;
        break;
      end
    end
    if (lat > 0) begin
      got_rx   = rx_data[sel];
      got_mosi = mosi_cap[sel];
      pulses   = rise_cnt[sel];
      got_or   = mosi_or[sel];
      check("done_cs_n", sel, 32'(cs_n[sel]), 32'd1);
      check("done_ready", sel, 32'(tx_ready[sel]), 32'd0);
      @(posedge clk); #1;
      check("after_ready", sel, 32'(tx_ready[sel]), 32'd1);
      check("rx_valid_pulse", sel, 32'(rx_valid[sel]), 32'd0);
    end
  endtask

  task automatic check_idle(input string name, input int sel);
    check({name, "_sclk"},  sel, 32'(sclk[sel]),     32'd0);
    check({name, "_cs_n"},  sel, 32'(cs_n[sel]),     32'd1);
    check({name, "_mosi"},  sel, 32'(mosi[sel]),     32'd0);
    check({name, "_rxv"},   sel, 32'(rx_valid[sel]), 32'd0);
    check({name, "_busy"},  sel, 32'(busy[sel]),     32'd0);
    check({name, "_ready"}, sel, 32'(tx_ready[sel]), 32'd1);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    int         sel;
    logic [7:0] tx;
    int         mode;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    int         exp_lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #(500_000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx, mo;
    int lat, pulses;
    logic mor;

    vecs[0] = '{0, 8'hA5, 0, 8'h00, 8'hA5, 32};
    vecs[1] = '{0, 8'h00, 1, 8'h00, 8'hFF, 32};
    vecs[2] = '{1, 8'h5A, 0, 8'h00, 8'h5A, 16};
    vecs[3] = '{0, 8'h3C, 2, 8'h96, 8'h96, 32};
    vecs[4] = '{1, 8'hFF, 1, 8'h00, 8'hFF, 16};
    vecs[5] = '{1, 8'h81, 2, 8'h4B, 8'h4B, 16};

    // Reset state, both instances, while CLR is still asserted.
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_idle("reset", i);
      check("reset_rx_data", i, 32'(rx_data[i]), 32'd0);
    end
    @(negedge clk);
    clr = 2'b00;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) check("ready_after_clr", i, 32'(tx_ready[i]), 32'd1);

    // Table-driven transfers.
    foreach (vecs[v]) begin
      do_xfer(vecs[v].sel, vecs[v].tx, vecs[v].mode, vecs[v].pat, rx, lat, mo, pulses, mor);
      check($sformatf("vec%0d_rx", v),     vecs[v].sel, 32'(rx),     32'(vecs[v].exp_rx));
      check($sformatf("vec%0d_lat", v),    vecs[v].sel, 32'(lat),    32'(vecs[v].exp_lat));
      check($sformatf("vec%0d_mosi", v),   vecs[v].sel, 32'(mo),     32'(vecs[v].tx));
      check($sformatf("vec%0d_pulses", v), vecs[v].sel, 32'(pulses), 32'd8);
      check($sformatf("vec%0d_mosi_or", v), vecs[v].sel, 32'(mor),   32'(vecs[v].tx != 8'h00));
    end

    // Abort after the 5th SCLK toggle, then a clean 8'h3C loopback.
    begin
      int n, pulses_seen;
      miso_mode[0] = 0;
      wait_ready(0);
      tx_data[0]  = 8'hC3;
      tx_valid[0] = 1'b1;
      @(posedge clk); #1;
      tx_valid[0] = 1'b0;
      n = 0;
      while (tog_cnt[0] < 5 && n < 100) begin
        @(negedge clk); #1;
        n++;
      end
      check("abort_toggles", 0, 32'(tog_cnt[0]), 32'd5);
      clr[0] = 1'b1;
      @(posedge clk); #1;
      check_idle("abort", 0);
      check("abort_rx_data", 0, 32'(rx_data[0]), 32'd0);
      @(negedge clk);
      clr[0] = 1'b0;
      pulses_seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (rx_valid[0] || busy[0]) pulses_seen++;
      end
      check("abort_quiet", 0, 32'(pulses_seen), 32'd0);
      do_xfer(0, 8'h3C, 0, 8'h00, rx, lat, mo, pulses, mor);
      check("post_abort_rx", 0, 32'(rx), 32'h3C);
      check("post_abort_lat", 0, 32'(lat), 32'd32);
    end

    // Back-to-back with TX_VALID held high: 8'h01 then 8'h80.
    for (int s = 0; s < 2; s++) begin
      int cyc, np, cs_hi, busy_after;
      int t [2];
      logic [7:0] d [2];
      miso_mode[s] = 0;
      wait_ready(s);
      tx_data[s]  = 8'h01;
      tx_valid[s] = 1'b1;
      cyc = 0; np = 0; cs_hi = 0;
      t = '{0, 0};
      d = '{8'h00, 8'h00};
      while (np < 2 && cyc < 200) begin
        @(posedge clk); #1;
        cyc++;
        if (rx_valid[s]) begin
          t[np] = cyc;
          d[np] = rx_data[s];
          np++;
        end
        if (np == 1 && cs_n[s]) cs_hi++;
        if (busy[s] && tx_data[s] == 8'h01) tx_data[s] = 8'h80;
        if (np == 1 && !cs_n[s]) tx_valid[s] = 1'b0;
      end
      tx_valid[s] = 1'b0;
      check("b2b_pulses", s, 32'(np), 32'd2);
      check("b2b_first", s, 32'(d[0]), 32'h01);
      check("b2b_second", s, 32'(d[1]), 32'h80);
      check("b2b_spacing", s, 32'(t[1] - t[0]), 32'(16 * div_of(s) + 2));
      check("b2b_cs_gap", s, 32'(cs_hi), 32'd2);
      busy_after = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (busy[s]) busy_after++;
      end
      check("b2b_no_third", s, 32'(busy_after), 32'd0);
    end

    // TX_VALID pulsed with 8'hFF while busy is ignored.
    for (int s = 0; s < 2; s++) begin
      int n, lat2, ready_hi, busy_after;
      logic [7:0] got;
      miso_mode[s] = 0;
      wait_ready(s);
      tx_data[s]  = 8'h96;
      tx_valid[s] = 1'b1;
      @(posedge clk); #1;
      tx_valid[s] = 1'b0;
      lat2 = -1; ready_hi = 0; got = 8'h00;
      for (n = 1; n <= 16 * div_of(s) + 20; n++) begin
        @(posedge clk); #1;
        if (n == 3) begin
          tx_data[s]  = 8'hFF;
          tx_valid[s] = 1'b1;
        end
        if (n == 4) tx_valid[s] = 1'b0;
        if (rx_valid[s]) begin
          lat2 = n;
          got  = rx_data[s];
          break;
        end
        if (tx_ready[s]) ready_hi++;
      end
      tx_valid[s] = 1'b0;
      check("ignore_ready_low", s, 32'(ready_hi), 32'd0);
      check("ignore_done_ready", s, 32'(tx_ready[s]), 32'd0);
      check("ignore_rx", s, 32'(got), 32'h96);
      check("ignore_lat", s, 32'(lat2), 32'(16 * div_of(s)));
      busy_after = 0;
      for (int c = 0; c < 30; c++) begin
        @(posedge clk); #1;
        if (busy[s]) busy_after++;
      end
      check("ignore_no_extra", s, 32'(busy_after), 32'd0);
    end

    // Randomized transfers against the reference: the received byte is the
    // byte the MISO source presents, and the MOSI stream is TX_DATA LSB first.
    for (int r = 0; r < 24; r++) begin
      int sel, mode;
      logic [7:0] tx, pat, exp_rx;
      sel  = $urandom_range(0, 1);
      mode = $urandom_range(0, 2);
      tx   = 8'($urandom);
      pat  = 8'($urandom);
      case (mode)
        0:       exp_rx = tx;
        1:       exp_rx = 8'hFF;
        default: exp_rx = pat;
      endcase
      exp_q.push_back(exp_rx);
      do_xfer(sel, tx, mode, pat, rx, lat, mo, pulses, mor);
      check("rand_rx", sel, 32'(rx), 32'(exp_q.pop_front()));
      check("rand_lat", sel, 32'(lat), 32'(16 * div_of(sel)));
      check("rand_mosi", sel, 32'(mo), 32'(tx));
      check("rand_pulses", sel, 32'(pulses), 32'd8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
